// File: rtl/alu_check.sv
// Passive response checker for the 8-bit ALU. It aligns a golden result with the ALU
// output through a LAT-deep valid pipeline and keeps saturating pass/fail statistics.
module alu_check #(
  parameter int LAT   = 1,
  parameter int CNT_W = 16
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  input  logic [3:0]       ctr,
  input  logic [7:0]       o,
  input  logic             clear,
  output logic [CNT_W-1:0] check_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err,
  output logic [35:0]      fail_info
);

  typedef struct packed {
    logic       vld;
    logic [3:0] ctr;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
  } entry_t;

  entry_t [LAT-1:0] pipe_q, pipe_d;
  logic [CNT_W-1:0] check_cnt_q, check_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             err_q, err_d;
  logic [35:0]      fail_info_q, fail_info_d;

  entry_t tail;
  logic   cmp_en;
  logic   mismatch;

  function automatic logic [7:0] golden(input logic [3:0] op, input logic [7:0] x,
                                        input logic [7:0] y);
    logic [7:0] r;
    case (op)
      4'h0:    r = x + y;
      4'h1:    r = x - y;
      4'h2:    r = x & y;
      4'h3:    r = x | y;
      4'h4:    r = x ^ y;
      4'h5:    r = ~(x | y);
      4'h6:    r = {x[6:0], 1'b0};
      4'h7:    r = {1'b0, x[7:1]};
      4'h8:    r = {x[6:0], x[7]};
      4'h9:    r = {x[0], x[7:1]};
      4'hA:    r = x + 8'd1;
      4'hB:    r = x - 8'd1;
      4'hC:    r = x;
      4'hD:    r = y;
      4'hE:    r = (x < y) ? 8'h01 : 8'h00;
      default: r = (x == y) ? 8'h01 : 8'h00;
    endcase
    return r;
  endfunction

  // Stage 0 captures the incoming operation; clear drops everything in flight, including it.
  always_comb begin
    pipe_d          = pipe_q;
    pipe_d[0].vld   = in_valid;
    pipe_d[0].ctr   = ctr;
    pipe_d[0].a     = a;
    pipe_d[0].b     = b;
    pipe_d[0].exp   = golden(ctr, a, b);
    for (int i = 1; i < LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
    if (clear) begin
      for (int i = 0; i < LAT; i++) begin
        pipe_d[i].vld = 1'b0;
      end
    end
  end

  assign tail     = pipe_q[LAT-1];
  assign cmp_en   = tail.vld;
  assign mismatch = tail.vld && (tail.exp != o);

  always_comb begin
    check_cnt_d = check_cnt_q;
    err_cnt_d   = err_cnt_q;
    err_d       = err_q;
    fail_info_d = fail_info_q;
    if (clear) begin
      check_cnt_d = '0;
      err_cnt_d   = '0;
      err_d       = 1'b0;
      fail_info_d = '0;
    end else begin
      if (cmp_en && (check_cnt_q != '1)) check_cnt_d = check_cnt_q + CNT_W'(1);
      if (mismatch && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + CNT_W'(1);
      if (mismatch) err_d = 1'b1;
      // Only the first failure is captured; later ones just bump the counter.
      if (mismatch && !err_q) fail_info_d = {tail.ctr, tail.a, tail.b, tail.exp, o};
    end
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      pipe_q      <= '0;
      check_cnt_q <= '0;
      err_cnt_q   <= '0;
      err_q       <= 1'b0;
      fail_info_q <= '0;
    end else begin
      pipe_q      <= pipe_d;
      check_cnt_q <= check_cnt_d;
      err_cnt_q   <= err_cnt_d;
      err_q       <= err_d;
      fail_info_q <= fail_info_d;
    end
  end

  assign check_cnt = check_cnt_q;
  assign err_cnt   = err_cnt_q;
  assign err       = err_q;
  assign fail_info = fail_info_q;

endmodule

// File: tb/tb_alu_check.sv
// Bench for alu_check: two instances (LAT=1/CNT_W=16 and LAT=3/CNT_W=4) share stimulus and
// are compared every cycle against a queue-based model of scheduled comparisons.
module tb_alu_check;

  logic        ck = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        clear = 1'b0;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic [3:0]  ctr = '0;
  logic [7:0]  inj = '0;
  logic [7:0]  hist [3];

  logic [15:0] chk1, errc1;
  logic        err1;
  logic [35:0] fi1;
  logic [3:0]  chk3, errc3;
  logic        err3;
  logic [35:0] fi3;

  int tests = 0;
  int fails = 0;
  bit checking = 1'b0;

  alu_check #(.LAT(1), .CNT_W(16)) u_lat1 (
    .ck(ck), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .ctr(ctr), .o(hist[0]),
    .clear(clear), .check_cnt(chk1), .err_cnt(errc1), .err(err1), .fail_info(fi1)
  );

  alu_check #(.LAT(3), .CNT_W(4)) u_lat3 (
    .ck(ck), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .ctr(ctr), .o(hist[2]),
    .clear(clear), .check_cnt(chk3), .err_cnt(errc3), .err(err3), .fail_info(fi3)
  );

  always #5 ck = ~ck;

  // Stand-in ALU: the value chosen for each operation appears 1 and 3 cycles later.
  always @(posedge ck) begin
    hist[2] <= hist[1];
    hist[1] <= hist[0];
    hist[0] <= inj;
  end

  function automatic logic [7:0] refAlu(input logic [3:0] op, input logic [7:0] x,
                                        input logic [7:0] y);
    int ia, ib, r;
    ia = int'(x);
    ib = int'(y);
    case (op)
      4'h0:    r = ia + ib;
      4'h1:    r = ia - ib + 256;
      4'h2:    r = int'(x & y);
      4'h3:    r = ia | ib;
      4'h4:    r = ia ^ ib;
      4'h5:    r = 255 - (ia | ib);
      4'h6:    r = ia * 2;
      4'h7:    r = ia / 2;
      4'h8:    r = ia * 2 + ia / 128;
      4'h9:    r = ia / 2 + (ia % 2) * 128;
      4'hA:    r = ia + 1;
      4'hB:    r = ia + 255;
      4'hC:    r = ia;
      4'hD:    r = ib;
      4'hE:    r = (ia < ib) ? 1 : 0;
      default: r = (ia == ib) ? 1 : 0;
    endcase
    return 8'(r % 256);
  endfunction

  typedef struct {
    int         cyc;
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
    logic [7:0] got;
  } op_t;

  op_t         pend[$];
  op_t         newOp;
  int          cyc = 0;
  int          lat [2] = '{1, 3};
  int          maxc [2] = '{65535, 15};
  int          mChk [2] = '{0, 0};
  int          mErr [2] = '{0, 0};
  bit          mSticky [2] = '{1'b0, 1'b0};
  logic [35:0] mInfo [2] = '{36'h0, 36'h0};

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      mChk[k]    = 0;
      mErr[k]    = 0;
      mSticky[k] = 1'b0;
      mInfo[k]   = '0;
    end
    pend.delete();
  endtask

  // Model: each operation is due for comparison lat[k] edges after it was sampled.
  always @(posedge ck or posedge rst) begin
    if (rst) begin
      modelReset();
    end else if (clear) begin
      modelReset();
      cyc++;
    end else begin
      foreach (pend[i]) begin
        for (int k = 0; k < 2; k++) begin
          if (pend[i].cyc + lat[k] == cyc) begin
            if (mChk[k] < maxc[k]) mChk[k]++;
            if (pend[i].got != pend[i].exp) begin
              if (mErr[k] < maxc[k]) mErr[k]++;
              if (!mSticky[k]) begin
                mSticky[k] = 1'b1;
                mInfo[k]   = {pend[i].op, pend[i].a, pend[i].b, pend[i].exp, pend[i].got};
              end
            end
          end
        end
      end
      while (pend.size() > 0 && pend[0].cyc + 3 <= cyc) void'(pend.pop_front());
      if (in_valid) begin
        newOp.cyc = cyc;
        newOp.op  = ctr;
        newOp.a   = a;
        newOp.b   = b;
        newOp.exp = refAlu(ctr, a, b);
        newOp.got = inj;
        pend.push_back(newOp);
      end
      cyc++;
    end
  end

  task automatic checkOutput(input string name, input logic [35:0] got, input logic [35:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  always @(negedge ck) begin
    if (checking) begin
      checkOutput("lat1 check_cnt", 36'(chk1), 36'(mChk[0]));
      checkOutput("lat1 err_cnt", 36'(errc1), 36'(mErr[0]));
      checkOutput("lat1 err", 36'(err1), 36'(mSticky[0]));
      checkOutput("lat1 fail_info", fi1, mInfo[0]);
      checkOutput("lat3 check_cnt", 36'(chk3), 36'(mChk[1]));
      checkOutput("lat3 err_cnt", 36'(errc3), 36'(mErr[1]));
      checkOutput("lat3 err", 36'(err3), 36'(mSticky[1]));
      checkOutput("lat3 fail_info", fi3, mInfo[1]);
    end
  end

  task automatic applyStimulus(input bit v, input logic [7:0] ia, input logic [7:0] ib,
                               input logic [3:0] ic, input logic [7:0] gotVal);
    @(negedge ck);
    clear    = 1'b0;
    in_valid = v;
    a        = ia;
    b        = ib;
    ctr      = ic;
    inj      = gotVal;
  endtask

  task automatic applyRandom(input bit v, input bit fault);
    logic [7:0] x, y;
    logic [3:0] op;
    x  = 8'($urandom);
    y  = 8'($urandom);
    op = 4'($urandom);
    applyStimulus(v, x, y, op,
                  fault ? refAlu(op, x, y) ^ 8'(1 + $urandom_range(0, 254)) : refAlu(op, x, y));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'($urandom), 8'($urandom), 4'($urandom), 8'($urandom));
  endtask

  task automatic pulseClear();
    @(negedge ck);
    clear    = 1'b1;
    in_valid = 1'b1;
    a        = 8'($urandom);
    b        = 8'($urandom);
    ctr      = 4'($urandom);
    inj      = 8'($urandom);
  endtask

  logic [3:0] edgeOps [6] = '{4'h0, 4'h1, 4'hA, 4'hB, 4'hE, 4'hF};
  logic [7:0] edgeExp [6] = '{8'h00, 8'hFE, 8'h00, 8'hFE, 8'h00, 8'h00};

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge ck);
    rst      = 1'b0;
    checking = 1'b1;

    idle(10);
    checkOutput("idle check_cnt", 36'(chk1), 36'h0);
    checkOutput("idle err", 36'(err1 | err3), 36'h0);

    for (int i = 0; i < 100; i++) applyRandom(1'b1, 1'b0);
    idle(4);
    checkOutput("random check_cnt", 36'(chk1), 36'd100);
    checkOutput("random err_cnt", 36'(errc1), 36'd0);
    checkOutput("random sat check_cnt", 36'(chk3), 36'hF);

    pulseClear();
    applyStimulus(1'b1, 8'h3C, 8'h05, 4'h0, 8'h40);
    idle(4);
    checkOutput("fault err", 36'(err1), 36'h1);
    checkOutput("fault err_cnt", 36'(errc1), 36'h1);
    checkOutput("fault fail_info", fi1, {4'h0, 8'h3C, 8'h05, 8'h41, 8'h40});
    checkOutput("fault fail_info lat3", fi3, {4'h0, 8'h3C, 8'h05, 8'h41, 8'h40});
    applyStimulus(1'b1, 8'h10, 8'h20, 4'h2, 8'hFF);
    idle(4);
    checkOutput("second fault err_cnt", 36'(errc1), 36'h2);
    checkOutput("second fault holds info", fi1, {4'h0, 8'h3C, 8'h05, 8'h41, 8'h40});

    for (int i = 0; i < 6; i++) begin
      checkOutput($sformatf("edge ref op %0h", edgeOps[i]), 36'(refAlu(edgeOps[i], 8'hFF, 8'h01)),
                  36'(edgeExp[i]));
    end
    pulseClear();
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 8'hFF, 8'h01, edgeOps[i], edgeExp[i]);
    idle(4);
    checkOutput("edge check_cnt", 36'(chk1), 36'd6);
    checkOutput("edge err_cnt", 36'(errc1), 36'd0);
    checkOutput("edge check_cnt lat3", 36'(chk3), 36'd6);

    pulseClear();
    for (int i = 0; i < 3; i++) applyRandom(1'b1, 1'b1);
    pulseClear();
    idle(5);
    checkOutput("flush check_cnt lat3", 36'(chk3), 36'd0);
    checkOutput("flush err lat3", 36'(err3), 36'd0);
    checkOutput("flush check_cnt lat1", 36'(chk1), 36'd0);

    for (int i = 0; i < 5; i++) applyRandom(1'b1, 1'b1);
    @(negedge ck);
    in_valid = 1'b0;
    clear    = 1'b0;
    #2 rst = 1'b1;
    #1;
    checkOutput("async rst check_cnt", 36'(chk1), 36'd0);
    checkOutput("async rst err_cnt", 36'(errc1), 36'd0);
    checkOutput("async rst fail_info", fi1, 36'h0);
    @(negedge ck);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) applyRandom(1'b1, 1'b1);
    idle(5);
    checkOutput("sat err_cnt", 36'(errc3), 36'hF);
    checkOutput("sat check_cnt", 36'(chk3), 36'hF);
    checkOutput("sat err", 36'(err3), 36'h1);
    checkOutput("sat lat1 err_cnt", 36'(errc1), 36'd20);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 39) == 0) pulseClear();
      else applyRandom($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);
    end
    idle(5);

    checking = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
